// File: rtl/decade_seq_checker.sv
// decade_seq_checker: locks onto a BCD 0..9 count on q_in and reports wraps,
// counter restarts, illegal codes and sequence breaks.
module decade_seq_checker #(
  parameter int CNT_W      = 8,
  parameter int LOCK_COUNT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [3:0]       q_in,
  output logic             locked,
  output logic             wrap,
  output logic             restart,
  output logic             err_illegal,
  output logic             err_seq,
  output logic [CNT_W-1:0] decade_cnt,
  output logic [7:0]       err_cnt
);
  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;
  localparam logic [3:0] LC = 4'(LOCK_COUNT);
  state_t state, state_n;
  logic [3:0] prev, prev_n, match, match_n, nxt;
  logic wrap_n, restart_n, ill_n, seq_n, legal, is_next;
  logic [CNT_W-1:0] dec_n;
  logic [7:0] err_n;
  assign nxt     = prev == 4'd9 ? 4'd0 : prev + 4'd1;
  assign legal   = q_in <= 4'd9;
  assign is_next = q_in == nxt;
  assign locked  = state == LOCKED;
  always_comb begin
    state_n   = state;
    prev_n    = prev;
    match_n   = match;
    wrap_n    = 1'b0;
    restart_n = 1'b0;
    ill_n     = 1'b0;
    seq_n     = 1'b0;
    dec_n     = decade_cnt;
    err_n     = err_cnt;
    if (en) begin
      if (!legal) begin
        ill_n   = 1'b1;
        state_n = SEARCH;
      end else begin
        case (state)
          SEARCH: begin
            prev_n  = q_in;
            match_n = 4'd0;
            state_n = ACQUIRE;
          end
          ACQUIRE: begin
            prev_n  = q_in;
            match_n = is_next ? match + 4'd1 : 4'd0;
            state_n = is_next && (match + 4'd1 == LC) ? LOCKED : ACQUIRE;
          end
          LOCKED: begin
            if (is_next) begin
              prev_n = q_in;
              wrap_n = prev == 4'd9;
              dec_n  = wrap_n ? decade_cnt + CNT_W'(1) : decade_cnt;
            end else if (q_in == 4'd0 && prev != 4'd0) begin
              // a drop to 0 from 1..8 means the counter was reset, not broken
              restart_n = 1'b1;
              prev_n    = 4'd0;
            end else begin
              seq_n   = 1'b1;
              state_n = SEARCH;
            end
          end
          default: state_n = SEARCH;
        endcase
      end
      err_n = (ill_n || seq_n) && err_cnt != 8'hFF ? err_cnt + 8'd1 : err_cnt;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= SEARCH;
      prev        <= 4'd0;
      match       <= 4'd0;
      wrap        <= 1'b0;
      restart     <= 1'b0;
      err_illegal <= 1'b0;
      err_seq     <= 1'b0;
      decade_cnt  <= '0;
      err_cnt     <= 8'd0;
    end else begin
      state       <= state_n;
      prev        <= prev_n;
      match       <= match_n;
      wrap        <= wrap_n;
      restart     <= restart_n;
      err_illegal <= ill_n;
      err_seq     <= seq_n;
      decade_cnt  <= dec_n;
      err_cnt     <= err_n;
    end
  end
endmodule

// File: tb/tb_decade_seq_checker.sv
// tb_decade_seq_checker: scoreboard bench; a driver pushes model expectations,
// a monitor pops and compares one entry per clock edge.
module tb_decade_seq_checker;
  localparam int LOCK = 2;
  typedef struct packed {
    logic       locked, wrap, restart, ill, seq;
    logic [7:0] dec, err;
  } obs_t;
  logic clk = 1'b0, reset = 1'b0, en = 1'b0;
  logic [3:0] q_in = 4'd0;
  logic locked, wrap, restart, err_illegal, err_seq;
  logic [7:0] decade_cnt, err_cnt;
  int checks = 0, errors = 0;
  obs_t exp_q[$];
  int m_mode = 0, m_prev = 0, m_match = 0, m_dec = 0, m_err = 0;
  decade_seq_checker #(.CNT_W(8), .LOCK_COUNT(LOCK)) dut (
    .clk(clk), .reset(reset), .en(en), .q_in(q_in), .locked(locked), .wrap(wrap),
    .restart(restart), .err_illegal(err_illegal), .err_seq(err_seq),
    .decade_cnt(decade_cnt), .err_cnt(err_cnt)
  );
  always #5 clk = ~clk;
  function automatic obs_t sample();
    obs_t o;
    o = {locked, wrap, restart, err_illegal, err_seq, decade_cnt, err_cnt};
    return o;
  endfunction
  task automatic chk(input string name, input int got, input int expv);
    checks++;
    if (got != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, expv);
    end
  endtask
  // Mode 0 = searching, 1 = acquiring, 2 = locked; counts follow the rules directly.
  task automatic step(input bit r, input bit e, input int q);
    obs_t x;
    int nx;
    @(negedge clk);
    reset = r;
    en    = e;
    q_in  = q[3:0];
    x     = '0;
    nx    = (m_prev + 1) % 10;
    if (!r) begin
      m_mode = 0; m_prev = 0; m_match = 0; m_dec = 0; m_err = 0;
    end else if (e) begin
      if (q > 9) begin
        x.ill = 1'b1; m_mode = 0;
      end else if (m_mode == 0) begin
        m_prev = q; m_match = 0; m_mode = 1;
      end else if (m_mode == 1) begin
        if (q == nx) begin
          m_match++;
          if (m_match == LOCK) m_mode = 2;
        end else m_match = 0;
        m_prev = q;
      end else if (q == nx) begin
        if (m_prev == 9) begin x.wrap = 1'b1; m_dec = (m_dec + 1) % 256; end
        m_prev = q;
      end else if (q == 0 && m_prev >= 1 && m_prev <= 8) begin
        x.restart = 1'b1; m_prev = 0;
      end else begin
        x.seq = 1'b1; m_mode = 0;
      end
      if (x.ill || x.seq) m_err = m_err < 255 ? m_err + 1 : 255;
    end
    x.locked = m_mode == 2;
    x.dec    = m_dec[7:0];
    x.err    = m_err[7:0];
    exp_q.push_back(x);
  endtask
  task automatic settle();
    @(posedge clk);
    #1;
  endtask
  always @(posedge clk) begin
    obs_t e, g;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = sample();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL scoreboard @%0t: got %h expected %h (locked,wrap,restart,ill,seq,dec,err)",
                 $time, g, e);
      end
    end
  end
  initial begin
    int c;
    int seqv[$];
    settle();
    chk("reset_outputs", int'(sample()), 0);
    for (int i = 0; i < 31; i++) step(1, 1, i % 10);
    settle();
    chk("three_decades", decade_cnt, 3);
    chk("no_errors", err_cnt, 0);
    chk("locked_run", locked, 1);
    seqv = '{1, 2, 3, 4, 0, 1};
    foreach (seqv[i]) step(1, 1, seqv[i]);
    settle();
    chk("restart_locked", locked, 1);
    chk("restart_no_err", err_cnt, 0);
    chk("restart_no_wrap", decade_cnt, 3);
    seqv = '{2, 3, 4, 5, 7};
    foreach (seqv[i]) step(1, 1, seqv[i]);
    settle();
    chk("skip_err_cnt", err_cnt, 1);
    chk("skip_unlocked", locked, 0);
    seqv = '{8, 9, 0};
    foreach (seqv[i]) step(1, 1, seqv[i]);
    settle();
    chk("relock", locked, 1);
    chk("relock_no_wrap", decade_cnt, 3);
    seqv = '{1, 2, 12, 12};
    foreach (seqv[i]) step(1, 1, seqv[i]);
    settle();
    chk("illegal_err_cnt", err_cnt, 3);
    chk("illegal_unlocked", locked, 0);
    for (int i = 0; i < 300; i++) step(1, 1, 15);
    settle();
    chk("err_saturate", err_cnt, 255);
    step(0, 0, 0);
    c = 0;
    for (int i = 0; i < 62; i++) begin
      step(1, i % 2 == 0, c);
      if (i % 2 == 0) c = (c + 1) % 10;
    end
    settle();
    chk("gated_decades", decade_cnt, 3);
    chk("gated_no_err", err_cnt, 0);
    chk("gated_locked", locked, 1);
    @(posedge clk);
    #2 reset = 1'b0;
    #1 chk("async_reset", int'(sample()), 0);
    step(0, 1, 5);
    c = 0;
    for (int i = 0; i < 600; i++) begin
      int v, q;
      bit e;
      v = $urandom_range(0, 19);
      q = v == 0 ? $urandom_range(0, 15) : v == 1 ? 0 : v == 2 ? $urandom_range(0, 9) : c;
      e = $urandom_range(0, 3) != 0;
      step($urandom_range(0, 99) != 0, e, q);
      if (e && q < 10) c = (q + 1) % 10;
    end
    step(1, 0, 0);
    @(posedge clk);
    #2 chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
